// File: rtl/keccak_share_compress.sv
// Share-compression stage for the masked Keccak chi S-box: registers the expanded
// (d+1)^2 product shares, then XOR-folds each row into d+1 output shares.
module keccak_share_compress #(
    parameter int d = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [(d+1)*(d+1)-1:0]   ap_in,
    input  logic [(d+1)*(d+1)-1:0]   bp_in,
    input  logic [(d+1)*(d+1)-1:0]   cp_in,
    input  logic [(d+1)*(d+1)-1:0]   dp_in,
    input  logic [(d+1)*(d+1)-1:0]   ep_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [d:0]               a_out,
    output logic [d:0]               b_out,
    output logic [d:0]               c_out,
    output logic [d:0]               d_out,
    output logic [d:0]               e_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_count
);
    localparam int N = d + 1;
    localparam int W = N * N;

    logic [4:0][W-1:0] w_in;
    logic [4:0][W-1:0] r_s1_data;
    logic              r_s1_valid;
    logic [4:0][N-1:0] w_comp;
    logic [4:0][N-1:0] r_s2_data;
    logic              r_s2_valid;
    logic [15:0]       r_count;
    logic              w_s2_free;
    logic              w_s1_free;
    logic              w_load1;

    assign w_in = {ep_in, dp_in, cp_in, bp_in, ap_in};

    // Stage 1 captures raw shares only; any XOR ahead of these flops would let
    // glitches combine shares of the same secret.
    genvar v, i;
    generate
        for (v = 0; v < 5; v++) begin : g_var
            for (i = 0; i < N; i++) begin : g_share
                assign w_comp[v][i] = ^r_s1_data[v][i*N +: N];
            end
        end
    endgenerate

    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;
    assign w_load1   = in_valid && w_s1_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_valid <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_load1) begin
                r_s1_data  <= w_in;
                r_s1_valid <= 1'b1;
            end else if (r_s1_valid && w_s2_free) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) r_s2_data <= w_comp;
            end
            if (r_s2_valid && out_ready) r_count <= r_count + 16'd1;
        end
    end

    assign in_ready  = w_s1_free;
    assign out_valid = r_s2_valid;
    assign a_out     = r_s2_data[0];
    assign b_out     = r_s2_data[1];
    assign c_out     = r_s2_data[2];
    assign d_out     = r_s2_data[3];
    assign e_out     = r_s2_data[4];
    assign out_count = r_count;
endmodule

// File: tb/tb_keccak_share_compress.sv
// Directed and randomized checks for keccak_share_compress at d=4.
module tb_keccak_share_compress;
    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] ap_in, bp_in, cp_in, dp_in, ep_in;
    logic        in_valid, in_ready;
    logic [4:0]  a_out, b_out, c_out, d_out, e_out;
    logic        out_valid, out_ready;
    logic [15:0] out_count;

    int checks = 0;
    int failures = 0;

    keccak_share_compress #(.d(4)) dut (
        .clk(clk), .rst(rst),
        .ap_in(ap_in), .bp_in(bp_in), .cp_in(cp_in), .dp_in(dp_in), .ep_in(ep_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out), .e_out(e_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [24:0] a, input logic [24:0] b, input logic [24:0] c,
                         input logic [24:0] dd, input logic [24:0] e);
        ap_in = a; bp_in = b; cp_in = c; dp_in = dd; ep_in = e;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        drive(25'h1FFFFFF, 25'h1FFFFFF, 0, 0, 0);
        step; step;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({a_out, b_out, c_out, d_out, e_out} !== 25'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {a_out, b_out, c_out, d_out, e_out}); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", out_count); end
        step;
        rst = 1'b0; in_valid = 1'b0; drive(0, 0, 0, 0, 0);
        step;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_count !== 16'h0) begin failures++; $display("FAIL reset_ignores_in_valid got=%b/%h exp=0/0", out_valid, out_count); end
        step;
    endtask

    task automatic test_all_ones;
        out_ready = 1'b1; in_valid = 1'b1;
        drive(25'h1FFFFFF, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ones_in_ready got=%b exp=1", in_ready); end
        step;
        in_valid = 1'b0; drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ones_latency1 got=%b exp=0", out_valid); end
        step;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ones_latency2 got=%b exp=1", out_valid); end
        checks++; if ({a_out, b_out, c_out, d_out, e_out} !== {5'b11111, 20'h0}) begin failures++; $display("FAIL ones_data got=%h exp=%h", {a_out, b_out, c_out, d_out, e_out}, {5'b11111, 20'h0}); end
        step;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_count !== 16'd1) begin failures++; $display("FAIL ones_count got=%b/%h exp=0/1", out_valid, out_count); end
        step;
    endtask

    task automatic test_share_index;
        out_ready = 1'b1; in_valid = 1'b1;
        drive(25'h0000001, 25'h0000020, 25'h0000003, 25'h0000400, 25'h1000000);
        step;
        in_valid = 1'b0; drive(0, 0, 0, 0, 0);
        step;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL idx_valid got=%b exp=1", out_valid); end
        checks++; if (a_out !== 5'b00001 || b_out !== 5'b00010 || e_out !== 5'b10000) begin failures++; $display("FAIL idx_abe got=%b/%b/%b exp=00001/00010/10000", a_out, b_out, e_out); end
        checks++; if (c_out !== 5'b00000 || d_out !== 5'b00100) begin failures++; $display("FAIL idx_cd got=%b/%b exp=00000/00100", c_out, d_out); end
        step;
        @(negedge clk);
        checks++; if (out_count !== 16'd2) begin failures++; $display("FAIL idx_count got=%h exp=2", out_count); end
        step;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0; in_valid = 1'b1;
        drive(25'h0000001, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_rdy1 got=%b exp=1", in_ready); end
        step;
        drive(25'h0000020, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_rdy2 got=%b exp=1", in_ready); end
        step;
        drive(25'h0000400, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_rdy3 got=%b exp=0", in_ready); end
        step;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || a_out !== 5'b00001) begin failures++; $display("FAIL b2b_stall got=%b/%b/%b exp=0/1/00001", in_ready, out_valid, a_out); end
        step;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || a_out !== 5'b00001) begin failures++; $display("FAIL b2b_release got=%b/%b exp=1/00001", in_ready, a_out); end
        step;
        in_valid = 1'b0; drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || a_out !== 5'b00010) begin failures++; $display("FAIL b2b_second got=%b/%b exp=1/00010", out_valid, a_out); end
        step;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || a_out !== 5'b00100) begin failures++; $display("FAIL b2b_third got=%b/%b exp=1/00100", out_valid, a_out); end
        step;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_count !== 16'd5) begin failures++; $display("FAIL b2b_drain got=%b/%h exp=0/5", out_valid, out_count); end
        step;
    endtask

    task automatic test_reset_full;
        out_ready = 1'b0; in_valid = 1'b1;
        drive(25'h1FFFFFF, 0, 0, 0, 0); step;
        drive(0, 25'h1FFFFFF, 0, 0, 0); step;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL rfull_pre got=%b/%b exp=1/0", out_valid, in_ready); end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        drive(0, 0, 25'h1FFFFFF, 0, 0);
        step;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_count !== 16'h0 || in_ready !== 1'b1 || a_out !== 5'b0) begin failures++; $display("FAIL rfull_post got=%b/%h/%b/%b exp=0/0/1/0", out_valid, out_count, in_ready, a_out); end
        rst = 1'b0; in_valid = 1'b0; drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step;
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rfull_stale%0d got=%b exp=0", k, out_valid); end
        end
        step;
    endtask

    task automatic test_wrap;
        bit found = 0;
        out_ready = 1'b1; in_valid = 1'b1;
        drive(25'h0000001, 0, 0, 0, 0);
        for (int n = 0; n < 70000; n++) begin
            @(negedge clk);
            if (out_count === 16'hFFFF) begin found = 1; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL wrap_reach got=%h exp=ffff", out_count); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b exp=1", out_valid); end
        @(negedge clk);
        checks++; if (out_count !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=0000", out_count); end
        in_valid = 1'b0;
        step;
    endtask

    task automatic test_random;
        logic [4:0]  q[$];
        logic [4:0]  exp_v, got_v;
        logic [24:0] prev_out;
        bit          stall_prev = 0;
        int          xfer = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step;
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom));
            in_valid  = (cyc < 2980) && ($urandom_range(0, 3) != 0);
            out_ready = (cyc >= 2980) || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stall_prev) begin
                checks++; if ({a_out, b_out, c_out, d_out, e_out} !== prev_out) begin failures++; $display("FAIL rnd_stable cyc=%0d got=%h exp=%h", cyc, {a_out, b_out, c_out, d_out, e_out}, prev_out); end
            end
            if (in_valid && in_ready) q.push_back({^ep_in, ^dp_in, ^cp_in, ^bp_in, ^ap_in});
            if (out_valid && out_ready) begin
                got_v = {^e_out, ^d_out, ^c_out, ^b_out, ^a_out};
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rnd_extra cyc=%0d got=%h exp=none", cyc, got_v);
                end else begin
                    exp_v = q.pop_front();
                    if (got_v !== exp_v) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, got_v, exp_v); end
                end
                xfer++;
            end
            checks++; if (q.size() > 2) begin failures++; $display("FAIL rnd_capacity cyc=%0d got=%0d exp<=2", cyc, q.size()); end
            stall_prev = out_valid && !out_ready;
            prev_out   = {a_out, b_out, c_out, d_out, e_out};
            step;
        end
        @(negedge clk);
        checks++; if (q.size() != 0 || out_valid !== 1'b0) begin failures++; $display("FAIL rnd_drain got=%0d/%b exp=0/0", q.size(), out_valid); end
        checks++; if (out_count !== xfer[15:0]) begin failures++; $display("FAIL rnd_count got=%h exp=%h", out_count, xfer[15:0]); end
        step;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(0, 0, 0, 0, 0);
        #1;
        test_reset;
        test_all_ones;
        test_share_index;
        test_back_to_back;
        test_reset_full;
        test_wrap;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
